// File: rtl/address_register_file_if.sv
// Datapath-side bundle of the address register file: load data, function and
// register selects, and the two combinational read ports.
interface address_register_file_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] I;
  logic [2:0]       FunSel;
  logic [2:0]       RegSel;
  logic [1:0]       OutCSel;
  logic [1:0]       OutDSel;
  logic [WIDTH-1:0] OutC;
  logic [WIDTH-1:0] OutD;

  modport master (
    output I, FunSel, RegSel, OutCSel, OutDSel,
    input  OutC, OutD
  );

  modport slave (
    input  I, FunSel, RegSel, OutCSel, OutDSel,
    output OutC, OutD
  );
endinterface

// File: rtl/address_register_file.sv
// Address register file: PC, AR and SP share one function select, each gated
// by its own active-low enable, with two independent combinational read ports.
module addressRegister #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enableN,
  input  logic [2:0]       funSel,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] qNext;

  always_comb begin
    qNext = Q;
    case (funSel)
      3'b000: qNext = Q - 1'b1;
      3'b001: qNext = Q + 1'b1;
      3'b010: qNext = dataIn;
      3'b011: qNext = '0;
      3'b100: qNext = {{(WIDTH-8){1'b0}}, dataIn[7:0]};
      3'b101: qNext[7:0] = dataIn[7:0];
      3'b110: qNext[15:8] = dataIn[7:0];
      3'b111: qNext = {{(WIDTH-8){dataIn[7]}}, dataIn[7:0]};
      default: qNext = Q;
    endcase
  end

  // The enable test comes first so an undriven function/data bus cannot
  // disturb a register that is holding.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Q <= '0;
    end else if (enableN == 1'b0) begin
      Q <= qNext;
    end
  end
endmodule

module address_register_file #(
  parameter int WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  address_register_file_if.slave bus
);
  logic [WIDTH-1:0] pcQ;
  logic [WIDTH-1:0] arQ;
  logic [WIDTH-1:0] spQ;

  addressRegister #(.WIDTH(WIDTH)) PC (
    .Clock  (Clock),
    .Reset  (Reset),
    .enableN(bus.RegSel[2]),
    .funSel (bus.FunSel),
    .dataIn (bus.I),
    .Q      (pcQ)
  );

  addressRegister #(.WIDTH(WIDTH)) AR (
    .Clock  (Clock),
    .Reset  (Reset),
    .enableN(bus.RegSel[1]),
    .funSel (bus.FunSel),
    .dataIn (bus.I),
    .Q      (arQ)
  );

  addressRegister #(.WIDTH(WIDTH)) SP (
    .Clock  (Clock),
    .Reset  (Reset),
    .enableN(bus.RegSel[0]),
    .funSel (bus.FunSel),
    .dataIn (bus.I),
    .Q      (spQ)
  );

  // Both selects 00 and 01 map to PC.
  always_comb begin
    bus.OutC = pcQ;
    case (bus.OutCSel)
      2'b10:   bus.OutC = arQ;
      2'b11:   bus.OutC = spQ;
      default: bus.OutC = pcQ;
    endcase
  end

  always_comb begin
    bus.OutD = pcQ;
    case (bus.OutDSel)
      2'b10:   bus.OutD = arQ;
      2'b11:   bus.OutD = spQ;
      default: bus.OutD = pcQ;
    endcase
  end
endmodule

// File: tb/tb_address_register_file.sv
// Scoreboard bench for address_register_file: directed scenarios followed by
// a randomised run checked against a small behavioural model.
module tb_address_register_file;
  localparam int W = 16;
  localparam int OBS_C  = 0;
  localparam int OBS_D  = 1;
  localparam int OBS_PC = 2;
  localparam int OBS_AR = 3;
  localparam int OBS_SP = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  address_register_file_if #(.WIDTH(W)) bus ();

  address_register_file #(.WIDTH(W)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          which;
    logic [15:0] exp;
  } expItem;

  expItem sb[$];
  logic [15:0] m [3];   // model: 0=PC, 1=AR, 2=SP

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int which);
    case (which)
      OBS_C:   return bus.OutC;
      OBS_D:   return bus.OutD;
      OBS_PC:  return dut.PC.Q;
      OBS_AR:  return dut.AR.Q;
      default: return dut.SP.Q;
    endcase
  endfunction

  task automatic expectVal(input string tag, input int which, input logic [15:0] exp);
    expItem e;
    e.tag   = tag;
    e.which = which;
    e.exp   = exp;
    sb.push_back(e);
  endtask

  task automatic scoreCheck();
    expItem e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal(e.tag, observe(e.which), e.exp);
    end
  endtask

  task automatic apply(input string name, input logic [2:0] rs, input logic [2:0] fs,
                       input logic [15:0] i);
    bus.RegSel = rs;
    bus.FunSel = fs;
    bus.I      = i;
    $display("txn %s Reset=%b RegSel=%b FunSel=%b I=%h", name, Reset, rs, fs, i);
    @(posedge Clock);
    #1;
    bus.RegSel = 3'b111;
  endtask

  function automatic logic [15:0] funModel(input logic [15:0] q, input logic [2:0] fs,
                                           input logic [15:0] i);
    case (fs)
      3'd0:    return q - 16'd1;
      3'd1:    return q + 16'd1;
      3'd2:    return i;
      3'd3:    return 16'h0000;
      3'd4:    return {8'h00, i[7:0]};
      3'd5:    return {q[15:8], i[7:0]};
      3'd6:    return {i[7:0], q[7:0]};
      default: return {{8{i[7]}}, i[7:0]};
    endcase
  endfunction

  function automatic logic [15:0] muxModel(input logic [1:0] sel);
    case (sel)
      2'b10:   return m[1];
      2'b11:   return m[2];
      default: return m[0];
    endcase
  endfunction

  initial begin
    logic [2:0]  rs;
    logic [2:0]  fs;
    logic [15:0] iv;
    logic [1:0]  cs;
    logic [1:0]  ds;

    bus.I       = '0;
    bus.FunSel  = 3'b010;
    bus.RegSel  = 3'b000;
    bus.OutCSel = 2'b00;
    bus.OutDSel = 2'b00;

    // Reset clears everything; every read select must then return 0.
    Reset = 1'b0;
    apply("reset", 3'b000, 3'b010, 16'hAAAA);
    Reset = 1'b1;
    expectVal("rst_pc", OBS_PC, 16'h0000);
    expectVal("rst_ar", OBS_AR, 16'h0000);
    expectVal("rst_sp", OBS_SP, 16'h0000);
    scoreCheck();
    for (int s = 0; s < 4; s++) begin
      bus.OutCSel = 2'(s);
      bus.OutDSel = 2'(3 - s);
      #1;
      expectVal("rst_outc", OBS_C, 16'h0000);
      expectVal("rst_outd", OBS_D, 16'h0000);
      scoreCheck();
    end

    // Scenario 1: preload PC and SP, then read with no update enabled.
    apply("loadPC", 3'b011, 3'b010, 16'h1234);
    apply("loadSP", 3'b110, 3'b010, 16'h5678);
    bus.RegSel  = 3'b111;
    bus.OutCSel = 2'b00;
    bus.OutDSel = 2'b11;
    #5;
    expectVal("t1_outc", OBS_C, 16'h1234);
    expectVal("t1_outd", OBS_D, 16'h5678);
    scoreCheck();

    // Held registers must ignore undefined function/data inputs.
    apply("holdX", 3'b111, 3'bxxx, 16'hxxxx);
    expectVal("holdx_pc", OBS_PC, 16'h1234);
    expectVal("holdx_sp", OBS_SP, 16'h5678);
    scoreCheck();

    // Scenario 2: PC and SP loaded, AR held.
    apply("loadAll", 3'b000, 3'b010, 16'h1234);
    apply("t2", 3'b010, 3'b010, 16'h3548);
    bus.OutCSel = 2'b10;
    bus.OutDSel = 2'b01;
    #1;
    expectVal("t2_outc_ar", OBS_C, 16'h1234);
    expectVal("t2_outd_pc", OBS_D, 16'h3548);
    expectVal("t2_sp", OBS_SP, 16'h3548);
    scoreCheck();

    // Scenario 3: increment and decrement wrap.
    apply("loadPC", 3'b011, 3'b010, 16'hFFFF);
    apply("inc", 3'b011, 3'b001, 16'h0000);
    expectVal("t3_inc_wrap", OBS_PC, 16'h0000);
    scoreCheck();
    apply("dec", 3'b011, 3'b000, 16'h0000);
    expectVal("t3_dec_wrap", OBS_PC, 16'hFFFF);
    scoreCheck();

    // Scenario 4: byte-wise loads on AR.
    apply("loadAR", 3'b101, 3'b010, 16'hABCD);
    apply("sext", 3'b101, 3'b111, 16'h0080);
    expectVal("t4_sext", OBS_AR, 16'hFF80);
    scoreCheck();
    apply("hiByte", 3'b101, 3'b110, 16'h0012);
    expectVal("t4_hi", OBS_AR, 16'h1280);
    scoreCheck();
    apply("loByte", 3'b101, 3'b101, 16'h0034);
    expectVal("t4_lo", OBS_AR, 16'h1234);
    scoreCheck();
    apply("zext", 3'b101, 3'b100, 16'h0034);
    expectVal("t4_zext", OBS_AR, 16'h0034);
    scoreCheck();

    // Scenario 6: clear SP only.
    apply("loadSP", 3'b110, 3'b010, 16'h0010);
    apply("clrSP", 3'b110, 3'b011, 16'h5555);
    expectVal("t6_sp", OBS_SP, 16'h0000);
    expectVal("t6_pc", OBS_PC, 16'hFFFF);
    expectVal("t6_ar", OBS_AR, 16'h0034);
    scoreCheck();

    // Scenario 5: reset overrides a load and only acts on the edge.
    apply("loadAll", 3'b000, 3'b010, 16'h4321);
    Reset       = 1'b0;
    bus.RegSel  = 3'b000;
    bus.FunSel  = 3'b010;
    bus.I       = 16'hFFFF;
    bus.OutCSel = 2'b00;
    bus.OutDSel = 2'b11;
    #2;
    expectVal("t5_pre_outc", OBS_C, 16'h4321);
    expectVal("t5_pre_outd", OBS_D, 16'h4321);
    scoreCheck();
    apply("t5rst", 3'b000, 3'b010, 16'hFFFF);
    Reset = 1'b1;
    expectVal("t5_pc", OBS_PC, 16'h0000);
    expectVal("t5_ar", OBS_AR, 16'h0000);
    expectVal("t5_sp", OBS_SP, 16'h0000);
    scoreCheck();

    // Randomised run against the model.
    m[0] = 16'h0000;
    m[1] = 16'h0000;
    m[2] = 16'h0000;
    for (int n = 0; n < 60; n++) begin
      rs = 3'($urandom_range(0, 7));
      fs = 3'($urandom_range(0, 7));
      iv = 16'($urandom);
      if (!rs[2]) m[0] = funModel(m[0], fs, iv);
      if (!rs[1]) m[1] = funModel(m[1], fs, iv);
      if (!rs[0]) m[2] = funModel(m[2], fs, iv);
      apply("rand", rs, fs, iv);
      cs = 2'($urandom_range(0, 3));
      ds = 2'($urandom_range(0, 3));
      bus.OutCSel = cs;
      bus.OutDSel = ds;
      #1;
      expectVal("rand_pc", OBS_PC, m[0]);
      expectVal("rand_ar", OBS_AR, m[1]);
      expectVal("rand_sp", OBS_SP, m[2]);
      expectVal("rand_outc", OBS_C, muxModel(cs));
      expectVal("rand_outd", OBS_D, muxModel(ds));
      scoreCheck();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
